// File: rtl/if_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, presents it to instruction memory, and latches the fetched
// word with its PC for decode. Branch redirects (B, CBZ, B.LT) take priority
// over load-use stalls and insert a 32'h0 bubble, which decodes as a no-op.
module if_stage #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              br_taken,
    input  logic              br_uncond,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [25:0]       br_imm,
    output logic [31:0]       if_id_inst,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic [31:0]       fetch_cnt
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

    logic [ADDR_W-1:0] pc_r;
    logic [31:0]       if_id_inst_r;
    logic [ADDR_W-1:0] if_id_pc_r;
    logic              if_id_valid_r;
    logic [31:0]       fetch_cnt_r;

    logic [ADDR_W-1:0] offset_s;
    logic [ADDR_W-1:0] target_s;
    logic [ADDR_W-1:0] pc_next_seq_s;

    // Sign-extend the branch immediate field for the branch kind and scale to bytes
    always_comb begin
        offset_s = {ADDR_W{1'b0}};
        if (br_uncond) begin
            offset_s = {{(ADDR_W-28){br_imm[25]}}, br_imm[25:0], 2'b00};
        end else begin
            offset_s = {{(ADDR_W-21){br_imm[23]}}, br_imm[23:5], 2'b00};
        end
    end

    // Carry out of the target/sequential adders is intentionally discarded
    assign target_s      = br_pc + offset_s;
    assign pc_next_seq_s = pc_r + PC_STEP;

    // PC and IF/ID register update: reset, then redirect, then stall, then fetch
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_r          <= RESET_PC;
            if_id_inst_r  <= 32'h0000_0000;
            if_id_pc_r    <= {ADDR_W{1'b0}};
            if_id_valid_r <= 1'b0;
            fetch_cnt_r   <= 32'h0000_0000;
        end else if (br_taken) begin
            pc_r          <= target_s;
            if_id_inst_r  <= 32'h0000_0000;
            if_id_pc_r    <= {ADDR_W{1'b0}};
            if_id_valid_r <= 1'b0;
            fetch_cnt_r   <= fetch_cnt_r;
        end else if (stall) begin
            pc_r          <= pc_r;
            if_id_inst_r  <= if_id_inst_r;
            if_id_pc_r    <= if_id_pc_r;
            if_id_valid_r <= if_id_valid_r;
            fetch_cnt_r   <= fetch_cnt_r;
        end else begin
            pc_r          <= pc_next_seq_s;
            if_id_inst_r  <= imem_rdata;
            if_id_pc_r    <= pc_r;
            if_id_valid_r <= 1'b1;
            fetch_cnt_r   <= fetch_cnt_r + 32'd1;
        end
    end

    assign imem_addr   = pc_r;
    assign if_id_inst  = if_id_inst_r;
    assign if_id_pc    = if_id_pc_r;
    assign if_id_valid = if_id_valid_r;
    assign fetch_cnt   = fetch_cnt_r;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: two instances (RESET_PC 0 and the
// top-of-memory word) are driven with shared directed then random stimulus
// and compared against a behavioural model after every rising edge.
module tb_if_stage;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        br_taken;
    logic        br_uncond;
    logic [63:0] br_pc;
    logic [25:0] br_imm;
    logic [63:0] imem_addr [2];
    logic [31:0] imem_rdata [2];
    logic [31:0] if_id_inst [2];
    logic [63:0] if_id_pc [2];
    logic        if_id_valid [2];
    logic [31:0] fetch_cnt [2];

    int          mem_mode;
    int          n_assert;
    int          n_fail;

    // Reference model state, one per instance
    logic [63:0] m_pc [2];
    logic [31:0] m_inst [2];
    logic [63:0] m_ipc [2];
    logic        m_valid [2];
    logic [31:0] m_cnt [2];
    logic [63:0] rst_pc [2];

    function automatic logic [31:0] mem_word(input logic [63:0] addr, input int mode);
        if (mode == 0) return {21'h0, addr[10:0]};
        else           return addr[31:0] ^ 32'h5A5A_C3C3;
    endfunction

    assign imem_rdata[0] = mem_word(imem_addr[0], mem_mode);
    assign imem_rdata[1] = mem_word(imem_addr[1], mem_mode);

    if_stage #(.ADDR_W(64), .RESET_PC(64'h0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr[0]), .imem_rdata(imem_rdata[0]),
        .stall(stall), .br_taken(br_taken), .br_uncond(br_uncond), .br_pc(br_pc),
        .br_imm(br_imm), .if_id_inst(if_id_inst[0]), .if_id_pc(if_id_pc[0]),
        .if_id_valid(if_id_valid[0]), .fetch_cnt(fetch_cnt[0])
    );

    if_stage #(.ADDR_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr[1]), .imem_rdata(imem_rdata[1]),
        .stall(stall), .br_taken(br_taken), .br_uncond(br_uncond), .br_pc(br_pc),
        .br_imm(br_imm), .if_id_inst(if_id_inst[1]), .if_id_pc(if_id_pc[1]),
        .if_id_valid(if_id_valid[1]), .fetch_cnt(fetch_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Branch target from the instruction's signed word offset
    function automatic logic [63:0] branch_target(input logic unc, input logic [63:0] bpc,
                                                  input logic [25:0] imm);
        longint off;
        if (unc) begin
            off = longint'(imm);
            if (imm[25]) off = off - (longint'(1) << 26);
        end else begin
            off = longint'(imm[23:5]);
            if (imm[23]) off = off - (longint'(1) << 19);
        end
        return bpc + 64'(off * 4);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_pc[k] = rst_pc[k]; m_inst[k] = 32'h0; m_ipc[k] = 64'h0;
                m_valid[k] = 1'b0; m_cnt[k] = 32'h0;
            end else if (br_taken) begin
                m_pc[k] = branch_target(br_uncond, br_pc, br_imm);
                m_inst[k] = 32'h0; m_ipc[k] = 64'h0; m_valid[k] = 1'b0;
            end else if (!stall) begin
                m_inst[k] = mem_word(m_pc[k], mem_mode);
                m_ipc[k] = m_pc[k];
                m_valid[k] = 1'b1;
                m_pc[k] = m_pc[k] + 64'd4;
                m_cnt[k] = m_cnt[k] + 32'd1;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("imem_addr%0d", k), imem_addr[k], m_pc[k]);
            chk($sformatf("if_id_inst%0d", k), {32'h0, if_id_inst[k]}, {32'h0, m_inst[k]});
            chk($sformatf("if_id_pc%0d", k), if_id_pc[k], m_ipc[k]);
            chk($sformatf("if_id_valid%0d", k), {63'h0, if_id_valid[k]}, {63'h0, m_valid[k]});
            chk($sformatf("fetch_cnt%0d", k), {32'h0, fetch_cnt[k]}, {32'h0, m_cnt[k]});
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [25:0] imm_tmp;
        logic [31:0] cnt_save;
        n_assert = 0; n_fail = 0; mem_mode = 0;
        rst_pc[0] = 64'h0; rst_pc[1] = 64'hFFFF_FFFF_FFFF_FFFC;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 64'h0; m_inst[k] = 32'h0; m_ipc[k] = 64'h0; m_valid[k] = 1'b0; m_cnt[k] = 32'h0;
        end
        reset_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_uncond = 1'b0;
        br_pc = 64'h0; br_imm = 26'h0;

        // Reset state
        step();
        chk("rst_pc0", imem_addr[0], 64'h0);
        chk("rst_valid0", {63'h0, if_id_valid[0]}, 64'h0);
        chk("rst_pc1", imem_addr[1], 64'hFFFF_FFFF_FFFF_FFFC);

        // Free run; instance 1 wraps on its first fetch
        reset_n = 1'b1;
        step();
        chk("wrap_pc1", imem_addr[1], 64'h0);
        chk("wrap_if_id_pc1", if_id_pc[1], 64'hFFFF_FFFF_FFFF_FFFC);
        step(); step(); step();
        chk("run_if_id_pc", if_id_pc[0], 64'hC);
        chk("run_valid", {63'h0, if_id_valid[0]}, 64'h1);
        chk("run_cnt", {32'h0, fetch_cnt[0]}, 64'd4);
        chk("run_addr", imem_addr[0], 64'h10);
        chk("run_inst", {32'h0, if_id_inst[0]}, 64'hC);

        // Stall three cycles at pc 0x8
        reset_n = 1'b0; step();
        reset_n = 1'b1; step(); step();
        chk("pre_stall_pc", imem_addr[0], 64'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", imem_addr[0], 64'h8);
            chk("stall_cnt", {32'h0, fetch_cnt[0]}, 64'd2);
        end
        stall = 1'b0;
        step();
        chk("unstall_if_id_pc", if_id_pc[0], 64'h8);
        chk("unstall_pc", imem_addr[0], 64'hC);

        // B redirect backwards by two words
        br_taken = 1'b1; br_uncond = 1'b1; br_pc = 64'h40; br_imm = 26'h3FFFFFE;
        step();
        chk("b_pc", imem_addr[0], 64'h38);
        chk("b_bubble_inst", {32'h0, if_id_inst[0]}, 64'h0);
        chk("b_bubble_valid", {63'h0, if_id_valid[0]}, 64'h0);
        br_taken = 1'b0;
        step();
        chk("b_after_if_id_pc", if_id_pc[0], 64'h38);

        // CBZ / B.LT redirects, forward and backward
        imm_tmp = 26'h3FFFFFF; imm_tmp[23:5] = 19'd3;
        br_taken = 1'b1; br_uncond = 1'b0; br_pc = 64'h20; br_imm = imm_tmp;
        step();
        chk("cbz_fwd_pc", imem_addr[0], 64'h2C);
        imm_tmp[23:5] = 19'h7FFFF; br_imm = imm_tmp;
        step();
        chk("cbz_back_pc", imem_addr[0], 64'h1C);

        // Branch beats stall
        br_uncond = 1'b1; br_pc = 64'h100; br_imm = 26'h0;
        step();
        chk("to_100_pc", imem_addr[0], 64'h100);
        br_taken = 1'b0; step();
        cnt_save = m_cnt[0];
        br_taken = 1'b1; stall = 1'b1; br_pc = 64'h1F0; br_imm = 26'd4;
        step();
        chk("br_stall_pc", imem_addr[0], 64'h200);
        chk("br_stall_valid", {63'h0, if_id_valid[0]}, 64'h0);
        chk("br_stall_cnt", {32'h0, fetch_cnt[0]}, {32'h0, cnt_save});

        // Reset during a stall
        br_taken = 1'b0; stall = 1'b1; reset_n = 1'b0;
        step();
        chk("rst_in_stall_pc1", imem_addr[1], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("rst_in_stall_cnt0", {32'h0, fetch_cnt[0]}, 64'h0);
        chk("rst_in_stall_ipc0", if_id_pc[0], 64'h0);
        stall = 1'b0; reset_n = 1'b1;

        // Random traffic
        mem_mode = 1;
        for (int i = 0; i < 400; i++) begin
            reset_n   = ($urandom_range(0, 49) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            br_taken  = ($urandom_range(0, 9) == 0);
            br_uncond = $urandom_range(0, 1) == 1;
            br_pc     = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
            br_imm    = 26'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
